// File: rtl/or_gate.sv
// Registered bitwise OR of two operands with a valid pulse, a combinational
// reduction flag on the result, and a clearable sticky "any-one" flag.
module or_gate #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic             any_hi,
  output logic             sticky
);

  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] c_reg;
  logic             out_valid_reg;
  logic             sticky_reg;
  logic             sticky_next;

  // Each result bit depends only on its own pair of operand bits.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_or_bit
      assign or_bits[gi] = a[gi] | b[gi];
    end
  endgenerate

  // A set event outranks a simultaneous clear so no event is ever lost.
  always_comb begin
    sticky_next = sticky_reg;
    if (in_valid && (|or_bits)) begin
      sticky_next = 1'b1;
    end else if (clr) begin
      sticky_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg         <= '0;
      out_valid_reg <= 1'b0;
      sticky_reg    <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      sticky_reg    <= sticky_next;
      if (in_valid) begin
        c_reg <= or_bits;
      end
    end
  end

  // any_hi is taken from the register only, so operand glitches never reach it.
  assign c         = c_reg;
  assign out_valid = out_valid_reg;
  assign any_hi    = |c_reg;
  assign sticky    = sticky_reg;

endmodule

// File: tb/tb_or_gate.sv
// Directed self-checking bench for or_gate; exercises a 1-bit and an 8-bit instance.
module tb_or_gate;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, iv1, clr1;
  logic       c1, ov1, ah1, st1;
  logic [7:0] a8, b8, c8;
  logic       iv8, clr8, ov8, ah8, st8;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  or_gate #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1), .clr(clr1),
    .c(c1), .out_valid(ov1), .any_hi(ah1), .sticky(st1)
  );

  or_gate #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(iv8), .clr(clr8),
    .c(c8), .out_valid(ov8), .any_hi(ah8), .sticky(st8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b0; clr1 = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b0; clr8 = 1'b0;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if ({c1, ov1, st1, ah1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_w1: got c/ov/st/any=%b expected 0000", {c1, ov1, st1, ah1});
    end else $display("reset_w1: c/ov/st/any=%b ok", {c1, ov1, st1, ah1});
    vectors++;
    if ({c8, ov8, st8, ah8} !== 11'b0) begin
      errors++;
      $display("FAIL reset_w8: got c=%h ov=%b st=%b any=%b expected all zero", c8, ov8, st8, ah8);
    end else $display("reset_w8: c=%h ov=%b st=%b any=%b ok", c8, ov8, st8, ah8);
  endtask

  task automatic test_truth_table();
    logic [1:0] pairs [4];
    logic       exp_c [4];
    logic       exp_st [4];
    pairs  = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_c  = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_st = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = pairs[i];
      iv1 = 1'b1;
      step();
      vectors++;
      if ({c1, ov1, ah1, st1} !== {exp_c[i], 1'b1, exp_c[i], exp_st[i]}) begin
        errors++;
        $display("FAIL truth_%b: got c/ov/any/st=%b expected %b", pairs[i],
                 {c1, ov1, ah1, st1}, {exp_c[i], 1'b1, exp_c[i], exp_st[i]});
      end else $display("truth_%b: c/ov/any/st=%b ok", pairs[i], {c1, ov1, ah1, st1});
    end
  endtask

  task automatic test_hold();
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({c1, ov1, ah1} !== 3'b101) begin
        errors++;
        $display("FAIL hold_%0d: got c/ov/any=%b expected 101", i, {c1, ov1, ah1});
      end else $display("hold_%0d: c/ov/any=%b ok", i, {c1, ov1, ah1});
    end
  endtask

  task automatic test_sticky();
    // clr alone clears
    clr1 = 1'b1; iv1 = 1'b0;
    step();
    clr1 = 1'b0;
    vectors++;
    if (st1 !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr: got %b expected 0", st1);
    end else $display("sticky_clr: sticky=%b ok", st1);
    // non-zero operands without in_valid must not set it or move c
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b0;
    step();
    vectors++;
    if ({st1, c1} !== 2'b01) begin
      errors++;
      $display("FAIL sticky_noval: got st/c=%b expected 01", {st1, c1});
    end else $display("sticky_noval: st/c=%b ok", {st1, c1});
    // accepted (0,1) sets
    a1 = 1'b0; b1 = 1'b1; iv1 = 1'b1;
    step();
    vectors++;
    if (st1 !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: got %b expected 1", st1);
    end else $display("sticky_set: sticky=%b ok", st1);
    // clr alone again
    iv1 = 1'b0; clr1 = 1'b1;
    step();
    vectors++;
    if (st1 !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr2: got %b expected 0", st1);
    end else $display("sticky_clr2: sticky=%b ok", st1);
    // clr with accepted (1,0): set wins
    a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1; clr1 = 1'b1;
    step();
    clr1 = 1'b0; iv1 = 1'b0;
    vectors++;
    if ({st1, c1, ov1} !== 3'b111) begin
      errors++;
      $display("FAIL sticky_set_wins: got st/c/ov=%b expected 111", {st1, c1, ov1});
    end else $display("sticky_set_wins: st/c/ov=%b ok", {st1, c1, ov1});
  endtask

  task automatic test_width8();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vc [3];
    va = '{8'hA0, 8'h0F, 8'h00};
    vb = '{8'h05, 8'h33, 8'h00};
    vc = '{8'hA5, 8'h3F, 8'h00};
    for (int i = 0; i < 3; i++) begin
      a8 = va[i]; b8 = vb[i]; iv8 = 1'b1;
      step();
      vectors++;
      if ({c8, ov8, ah8, st8} !== {vc[i], 1'b1, (vc[i] != 8'h00), 1'b1}) begin
        errors++;
        $display("FAIL w8_%h_%h: got c=%h ov=%b any=%b st=%b expected c=%h ov=1 any=%b st=1",
                 va[i], vb[i], c8, ov8, ah8, st8, vc[i], (vc[i] != 8'h00));
      end else $display("w8_%h_%h: c=%h ov=%b any=%b st=%b ok", va[i], vb[i], c8, ov8, ah8, st8);
    end
  endtask

  task automatic test_back_to_back();
    // a result, then an idle cycle: c holds, out_valid drops
    a8 = 8'h81; b8 = 8'h18; iv8 = 1'b1;
    step();
    a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b0;
    vectors++;
    if ({c8, ov8} !== {8'h99, 1'b1}) begin
      errors++;
      $display("FAIL b2b_accept: got c=%h ov=%b expected c=99 ov=1", c8, ov8);
    end else $display("b2b_accept: c=%h ov=%b ok", c8, ov8);
    step();
    vectors++;
    if ({c8, ov8, ah8} !== {8'h99, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_idle: got c=%h ov=%b any=%b expected c=99 ov=0 any=1", c8, ov8, ah8);
    end else $display("b2b_idle: c=%h ov=%b any=%b ok", c8, ov8, ah8);
  endtask

  task automatic test_reset_midstream();
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({c1, ov1, st1, ah1} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid: got c/ov/st/any=%b expected 0000", {c1, ov1, st1, ah1});
    end else $display("rst_mid: c/ov/st/any=%b ok", {c1, ov1, st1, ah1});
    iv1 = 1'b0;
    step();
    vectors++;
    if ({c1, ov1, st1} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_after: got c/ov/st=%b expected 000", {c1, ov1, st1});
    end else $display("rst_mid_after: c/ov/st=%b ok", {c1, ov1, st1});
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_sticky();
    test_width8();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
